spm: RTL and testbench

SPM -- requirements
Module: spm

---
 rtl/spm_pkg.sv | 12 +
 rtl/spm_csa.sv | 35 +++
 rtl/spm.sv | 99 +++++++++
 tb/tb_spm.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/spm_pkg.sv
// Shared constants and state encoding for the serial-parallel multiplier.
package spm_pkg;

    localparam int unsigned SPM_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } spm_state_e;

endpackage

// File: rtl/spm_csa.sv
// Single-bit carry-save cell: adds (a & b) + neighbour sum + own carry and
// keeps the sum and carry in local registers.
module spm_csa (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    input  logic i_a,
    input  logic i_b,
    input  logic i_sum,
    output logic o_sum
);

    logic       r_sum;
    logic       r_carry;
    logic [1:0] w_tot;

    assign w_tot = 2'(i_a & i_b) + 2'(i_sum) + 2'(r_carry);
    assign o_sum = r_sum;

    // Sum/carry registers: cleared on operation launch, advance one step per busy cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sum   <= 1'b0;
            r_carry <= 1'b0;
        end else if (i_clr) begin
            r_sum   <= 1'b0;
            r_carry <= 1'b0;
        end else if (i_en) begin
            r_sum   <= w_tot[0];
            r_carry <= w_tot[1];
        end
    end

endmodule

// File: rtl/spm.sv
// Serial-parallel unsigned multiplier: MC held in parallel, MP shifted in
// LSB-first, one product bit retired per busy cycle into a shift register.
module spm
    import spm_pkg::*;
#(
    parameter int unsigned WIDTH = SPM_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     MP,
    input  logic [WIDTH-1:0]     MC,
    input  logic                 start,
    output logic [2*WIDTH-1:0]   P,
    output logic                 done
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(PW + 1);

    spm_state_e       r_state;
    logic [WIDTH-1:0] r_mc;
    logic [WIDTH-1:0] r_mp;
    logic [CW-1:0]    r_cnt;
    // Lowest product bit lives in s[0] only after the first busy edge, so the
    // first shifted-in bit is stale and falls off the bottom of this register.
    logic [PW-2:0]    r_shift;

    logic [WIDTH-1:0] w_sum_q;
    logic             w_bit;
    logic             w_clr;
    logic             w_en;

    assign w_bit = r_mp[0];
    assign w_clr = (r_state == IDLE) && start;
    assign w_en  = (r_state == BUSY);

    // Carry-save chain: cell i takes its sum input from cell i+1 (zero at the top).
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic w_sin;
        if (i == WIDTH - 1) begin : g_top
            assign w_sin = 1'b0;
        end else begin : g_mid
            assign w_sin = w_sum_q[i+1];
        end
        spm_csa u_csa (
            .clk   (clk),
            .rst   (rst),
            .i_clr (w_clr),
            .i_en  (w_en),
            .i_a   (r_mc[i]),
            .i_b   (w_bit),
            .i_sum (w_sin),
            .o_sum (w_sum_q[i])
        );
    end

    // Control FSM, operand capture, product shift register and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_mc    <= '0;
            r_mp    <= '0;
            r_cnt   <= '0;
            r_shift <= '0;
            P       <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_mc    <= MC;
                        r_mp    <= MP;
                        r_cnt   <= CW'(PW);
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    r_mp    <= r_mp >> 1;
                    r_shift <= {w_sum_q[0], r_shift[PW-2:1]};
                    r_cnt   <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    // s[0] now holds the final (MSB) product bit.
                    P       <= {w_sum_q[0], r_shift};
                    done    <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spm.sv
// Scoreboard bench for spm: stimulus pushes expected product and done cycle,
// a negedge monitor pops and compares whenever done is seen.
module tb_spm;
    import spm_pkg::*;

    localparam int unsigned W  = SPM_WIDTH;
    localparam int unsigned PW = 2 * W;

    typedef struct {
        logic [PW-1:0] p;
        int unsigned   due;
    } exp_t;

    logic          clk;
    logic          rst;
    logic [W-1:0]  MP;
    logic [W-1:0]  MC;
    logic          start;
    logic [PW-1:0] P;
    logic          done;

    exp_t          sb[$];
    int unsigned   cyc;
    int unsigned   checks;
    int unsigned   failures;
    logic          prev_done;
    logic [PW-1:0] p_hold;

    spm #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .MP    (MP),
        .MC    (MC),
        .start (start),
        .P     (P),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest expectation in value and cycle.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            chk("done_width", 64'(prev_done), 64'(0));
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=P:%h expected=no_done at cycle %0d", P, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("product", P, e.p);
                chk("latency", 64'(cyc), 64'(e.due));
            end
        end
        prev_done = done;
    end

    // Launch one operation at a negedge; returns just after its done edge.
    task automatic launch(input logic [W-1:0] mc, input logic [W-1:0] mp,
                          input logic [PW-1:0] p_exp);
        MC    = mc;
        MP    = mp;
        start = 1'b1;
        sb.push_back('{p_exp, cyc + 66});
        @(negedge clk);
        start = 1'b0;
        MC    = $urandom;
        MP    = $urandom;
        repeat (32) @(negedge clk);
        chk("p_hold_busy", P, p_hold);
        repeat (33) @(negedge clk);
        p_hold = p_exp;
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        checks    = 0;
        failures  = 0;
        prev_done = 1'b0;
        p_hold    = '0;
        rst       = 1'b0;
        start     = 1'b0;
        MC        = '0;
        MP        = '0;

        repeat (3) @(negedge clk);
        chk("reset_P", P, '0);
        chk("reset_done", 64'(done), 64'(0));

        // Release reset and start on the very first active edge.
        rst = 1'b1;
        launch(32'd3, 32'd2, 64'h0000000000000006);
        launch(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001);
        launch(32'd50, 32'hFFFFFFCE, 64'h00000031FFFFF63C);
        launch(32'd0, 32'h12345678, 64'h0);

        // Second start mid-busy is ignored.
        MC = 32'd5; MP = 32'd4; start = 1'b1;
        sb.push_back('{64'd20, cyc + 66});
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        MC = 32'd7; MP = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (55) @(negedge clk);
        p_hold = 64'd20;

        // Start held high across DONE: relaunch on first idle edge.
        MC = 32'd6; MP = 32'd7; start = 1'b1;
        sb.push_back('{64'd42, cyc + 66});
        sb.push_back('{64'd42, cyc + 132});
        repeat (66) @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (65) @(negedge clk);
        p_hold = 64'd42;

        // Reset partway through an operation aborts it.
        MC = 32'd123; MP = 32'd456; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_P", P, '0);
        chk("abort_done", 64'(done), 64'(0));
        p_hold = '0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (70) @(negedge clk);
        launch(32'd9, 32'd9, 64'd81);

        // Back-to-back random operations.
        for (int n = 0; n < 1000; n++) begin
            a = $urandom;
            b = $urandom;
            launch(a, b, 64'(a) * 64'(b));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
